mario_motion_ctrl: RTL and testbench
====================================

Name: mario_motion_ctrl

Overview:
- Consumes the 50 Hz game-tick level from the clock divider and steps Mario's position and velocity once per tick.
- Runs entirely on the 50 MHz system clock and detects rising edges of the tick level internally.
- Decodes left/right/jump buttons, applies walk speed, jump impulse, gravity, floor and screen clamping.
- Drives sprite position and state to the renderer.

Parameters:
- START_X, 32, reset x position (pixels)
- FLOOR_Y, 416, ground y position; y grows downward
- X_MIN, 0, leftmost legal x
- X_MAX, 608, rightmost legal x (640 minus 32-px sprite)
- WALK_SPEED, 2, pixels per tick of horizontal motion
- JUMP_VEL, 12, initial upward speed (pixels/tick)
- GRAVITY, 1, velocity increment per tick
- MAX_FALL, 12, downward velocity cap

Ports:
- clock50mHz  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- game_tick  in  1  50 Hz divided clock level from the divider
- enable  in  1  1 = process ticks; 0 = freeze all state
- btn_left  in  1  move-left button, active-high
- btn_right  in  1  move-right button, active-high
- btn_jump  in  1  jump button, active-high, level-sensitive
- pos_x  out  10  sprite x, unsigned
- pos_y  out  10  sprite y, unsigned
- facing_left  out  1  1 = sprite faces left
- motion_state  out  2  0=IDLE, 1=WALK, 2=RISE, 3=FALL
- update_strobe  out  1  one-cycle pulse coinciding with newly updated outputs

Behaviour:
- Reset is synchronous and active-high. On a clock edge with reset=1:
  - pos_x=START_X, pos_y=FLOOR_Y, vel_y=0, facing_left=0, motion_state=IDLE, update_strobe=0.
  - Tick-delay register tick_d=1, so a high game_tick at reset release produces no spurious step.
  - Reset mid-jump aborts the jump immediately; no landing is completed.
- Edge detect:
  - tick_d <= game_tick every cycle.
  - tick_rise = game_tick & ~tick_d.
- Step condition: tick_rise & enable. All updates below occur on that clock edge; update_strobe=1 for exactly that following cycle, else 0.
- When enable=0: a rise is discarded, not deferred. tick_d still tracks game_tick.
- Horizontal motion, applied in every state:
  - left-only: facing_left=1; x = (x < X_MIN+WALK_SPEED) ? X_MIN : x-WALK_SPEED.
  - right-only: facing_left=0; x = (x > X_MAX-WALK_SPEED) ? X_MAX : x+WALK_SPEED.
  - Both or neither pressed: x and facing_left unchanged.
  - "moving" = exactly one direction button pressed, even when clamped.
- vel_y: 8-bit signed, negative = upward. Position arithmetic is done in 11-bit signed, then clamped.
- IDLE/WALK:
  - btn_jump=1: y = y-JUMP_VEL; vel_y = -JUMP_VEL+GRAVITY; go to RISE.
  - Otherwise: vel_y=0; state = moving ? WALK : IDLE.
- RISE:
  - y_next = y+vel_y.
  - If y_next<0: y=0, vel_y=0, go to FALL.
  - Else: y=y_next, vel_y=vel_y+GRAVITY; if the new vel_y >= 0, go to FALL.
  - btn_jump is ignored.
- FALL:
  - y_next = y+vel_y.
  - If y_next >= FLOOR_Y: y=FLOOR_Y, vel_y=0; state = moving ? WALK : IDLE (landing tick).
  - Else: y=y_next, vel_y=min(vel_y+GRAVITY, MAX_FALL).
  - btn_jump is ignored.
- Jump held through landing re-jumps on the first tick after the landing tick; no release is required.
- Latency: outputs reflect a tick 1 system clock after the cycle in which game_tick is first sampled high.
- Outputs are registered only; no combinational path from inputs to outputs.

Test Plan:
- Reset with game_tick held high, 10 cycles, release, game_tick stays high 1000 cycles -> pos=(32,416), state IDLE, no update_strobe.
- btn_right held for 5 ticks -> pos_x 34,36,38,40,42; state WALK; facing_left=0; exactly 5 strobes, each 1 cycle wide. Release -> next tick IDLE, x=42.
- btn_left held from x=32 for 20 ticks -> x decreases by 2 per tick, clamps to 0 on tick 16 and stays 0; facing_left=1; state WALK throughout.
- btn_jump pulsed for one tick, defaults -> tick1 y=404 RISE; minimum y=338 reached on tick 12, entering FALL; tick 25 y=416, state IDLE; y never exceeds 416.
- enable=0 during ticks 3-5 of a jump -> pos, vel, state frozen and no strobe. Re-enable -> trajectory resumes from tick 3 values.
- Mid-FALL reset pulse (1 cycle) -> next cycle pos=(32,416), IDLE, vel 0. Following tick with no buttons -> state stays IDLE.

Source files
------------

// File: rtl/mario_motion_ctrl.sv
// mario_motion_ctrl
// Steps Mario's sprite position and vertical velocity once per rising edge of
// the 50 Hz game-tick level, sampled on the 50 MHz system clock. Handles walk,
// jump impulse, gravity, floor landing and screen-edge clamping. All outputs
// come straight from registers.
module mario_motion_ctrl #(
  parameter int START_X    = 32,
  parameter int FLOOR_Y    = 416,
  parameter int X_MIN      = 0,
  parameter int X_MAX      = 608,
  parameter int WALK_SPEED = 2,
  parameter int JUMP_VEL   = 12,
  parameter int GRAVITY    = 1,
  parameter int MAX_FALL   = 12
) (
  input  logic       clock50mHz,
  input  logic       reset,
  input  logic       game_tick,
  input  logic       enable,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       facing_left,
  output logic [1:0] motion_state,
  output logic       update_strobe
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_RISE = 2'd2,
    ST_FALL = 2'd3
  } state_t;

  // Position constants in the 10-bit pixel domain
  localparam logic [9:0] START_X_C  = 10'(START_X);
  localparam logic [9:0] FLOOR_Y_C  = 10'(FLOOR_Y);
  localparam logic [9:0] X_MIN_C    = 10'(X_MIN);
  localparam logic [9:0] X_MAX_C    = 10'(X_MAX);
  localparam logic [9:0] WALK_C     = 10'(WALK_SPEED);
  localparam logic [9:0] JUMP_C     = 10'(JUMP_VEL);
  // Clamp thresholds: beyond these a full walk step would cross the edge
  localparam logic [9:0] X_LO_LIM   = 10'(X_MIN + WALK_SPEED);
  localparam logic [9:0] X_HI_LIM   = 10'(X_MAX - WALK_SPEED);
  // Floor in the 11-bit signed arithmetic domain used for vertical motion
  localparam logic signed [10:0] FLOOR_S = 11'(FLOOR_Y);
  // Velocity constants (8-bit signed, negative = upward)
  localparam logic signed [7:0] GRAV_S     = 8'(GRAVITY);
  localparam logic signed [7:0] MAX_FALL_S = 8'(MAX_FALL);
  // A jump applies its impulse and the first gravity increment in one tick
  localparam logic signed [7:0] VEL_JUMP_S = 8'(GRAVITY - JUMP_VEL);

  // Architectural state
  logic [9:0]        pos_x_r;
  logic [9:0]        pos_y_r;
  logic signed [7:0] vel_y_r;
  logic              facing_left_r;
  state_t            state_r;
  logic              strobe_r;
  logic              tick_d_r;

  // Combinational next-state values
  logic               tick_rise_s;
  logic               step_s;
  logic               move_left_s;
  logic               move_right_s;
  logic               moving_s;
  logic [9:0]         x_next_s;
  logic               face_next_s;
  logic [9:0]         y_next_s;
  logic signed [7:0]  vel_next_s;
  state_t             state_next_s;
  logic signed [10:0] y_sum_s;
  logic signed [7:0]  vel_inc_s;

  assign tick_rise_s  = game_tick & ~tick_d_r;
  assign step_s       = tick_rise_s & enable;
  assign move_left_s  = btn_left & ~btn_right;
  assign move_right_s = btn_right & ~btn_left;
  // "Moving" means exactly one direction is pressed, even when clamped at an edge
  assign moving_s     = move_left_s | move_right_s;

  // Candidate y after applying the current velocity, in 11-bit signed so
  // overshoot above the top of the screen is visible as a negative value
  assign y_sum_s   = $signed({1'b0, pos_y_r}) + $signed({{3{vel_y_r[7]}}, vel_y_r});
  assign vel_inc_s = vel_y_r + GRAV_S;

  // Horizontal step with screen-edge clamping; applies in every motion state
  always_comb begin
    x_next_s    = pos_x_r;
    face_next_s = facing_left_r;
    if (move_left_s) begin
      face_next_s = 1'b1;
      if (pos_x_r < X_LO_LIM) begin
        x_next_s = X_MIN_C;
      end else begin
        x_next_s = pos_x_r - WALK_C;
      end
    end else if (move_right_s) begin
      face_next_s = 1'b0;
      if (pos_x_r > X_HI_LIM) begin
        x_next_s = X_MAX_C;
      end else begin
        x_next_s = pos_x_r + WALK_C;
      end
    end else begin
      x_next_s    = pos_x_r;
      face_next_s = facing_left_r;
    end
  end

  // Vertical step and motion-state transition for one game tick
  always_comb begin
    y_next_s     = pos_y_r;
    vel_next_s   = vel_y_r;
    state_next_s = state_r;
    case (state_r)
      ST_IDLE, ST_WALK: begin
        if (btn_jump) begin
          y_next_s     = pos_y_r - JUMP_C;
          vel_next_s   = VEL_JUMP_S;
          state_next_s = ST_RISE;
        end else begin
          y_next_s     = pos_y_r;
          vel_next_s   = 8'sd0;
          state_next_s = moving_s ? ST_WALK : ST_IDLE;
        end
      end
      ST_RISE: begin
        if (y_sum_s < 11'sd0) begin
          // Hit the top of the screen: stop dead and start falling
          y_next_s     = 10'd0;
          vel_next_s   = 8'sd0;
          state_next_s = ST_FALL;
        end else begin
          y_next_s     = y_sum_s[9:0];
          vel_next_s   = vel_inc_s;
          state_next_s = vel_inc_s[7] ? ST_RISE : ST_FALL;
        end
      end
      ST_FALL: begin
        if (y_sum_s >= FLOOR_S) begin
          // Landing tick: snap to the floor, jump is only honoured next tick
          y_next_s     = FLOOR_Y_C;
          vel_next_s   = 8'sd0;
          state_next_s = moving_s ? ST_WALK : ST_IDLE;
        end else begin
          y_next_s     = y_sum_s[9:0];
          vel_next_s   = (vel_inc_s > MAX_FALL_S) ? MAX_FALL_S : vel_inc_s;
          state_next_s = ST_FALL;
        end
      end
      default: begin
        y_next_s     = FLOOR_Y_C;
        vel_next_s   = 8'sd0;
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Tick edge tracking plus the motion FSM and its registered outputs
  always_ff @(posedge clock50mHz) begin
    if (reset) begin
      // tick_d starts high so a tick already high at release is not a rise
      tick_d_r      <= 1'b1;
      pos_x_r       <= START_X_C;
      pos_y_r       <= FLOOR_Y_C;
      vel_y_r       <= 8'sd0;
      facing_left_r <= 1'b0;
      state_r       <= ST_IDLE;
      strobe_r      <= 1'b0;
    end else begin
      tick_d_r <= game_tick;
      strobe_r <= step_s;
      if (step_s) begin
        pos_x_r       <= x_next_s;
        pos_y_r       <= y_next_s;
        vel_y_r       <= vel_next_s;
        facing_left_r <= face_next_s;
        state_r       <= state_next_s;
      end else begin
        // Disabled or no rise: the tick is dropped, state holds
        pos_x_r       <= pos_x_r;
        pos_y_r       <= pos_y_r;
        vel_y_r       <= vel_y_r;
        facing_left_r <= facing_left_r;
        state_r       <= state_r;
      end
    end
  end

  assign pos_x         = pos_x_r;
  assign pos_y         = pos_y_r;
  assign facing_left   = facing_left_r;
  assign motion_state  = state_r;
  assign update_strobe = strobe_r;

endmodule

// File: tb/tb_mario_motion_ctrl.sv
// Self-checking bench for mario_motion_ctrl: directed steps, a reference
// motion model feeding an expected-result queue, and a strobe-driven monitor.
module tb_mario_motion_ctrl;

  logic       clock50mHz = 1'b0;
  logic       reset;
  logic       game_tick;
  logic       enable;
  logic       btn_left;
  logic       btn_right;
  logic       btn_jump;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic       facing_left;
  logic [1:0] motion_state;
  logic       update_strobe;

  always #10 clock50mHz = ~clock50mHz;

  mario_motion_ctrl dut (
    .clock50mHz   (clock50mHz),
    .reset        (reset),
    .game_tick    (game_tick),
    .enable       (enable),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_jump     (btn_jump),
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .facing_left  (facing_left),
    .motion_state (motion_state),
    .update_strobe(update_strobe)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int n_strobe = 0;

  // Reference model state (ints, spec-level arithmetic)
  int m_x, m_y, m_v, m_f, m_st;

  typedef struct {
    int x;
    int y;
    int f;
    int st;
  } exp_t;
  exp_t q[$];
  exp_t e;
  logic prev_strobe = 1'b0;

  task automatic chk(input string tag, input int obs, input int expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_x = 32; m_y = 416; m_v = 0; m_f = 0; m_st = 0;
  endtask

  task automatic model_step();
    int yn;
    bit mv;
    mv = (btn_left != btn_right);
    if (btn_left && !btn_right) begin
      m_f = 1;
      m_x = (m_x < 2) ? 0 : m_x - 2;
    end
    if (btn_right && !btn_left) begin
      m_f = 0;
      m_x = (m_x > 606) ? 608 : m_x + 2;
    end
    case (m_st)
      0, 1: begin
        if (btn_jump) begin
          m_y = m_y - 12; m_v = -11; m_st = 2;
        end else begin
          m_v = 0; m_st = mv ? 1 : 0;
        end
      end
      2: begin
        yn = m_y + m_v;
        if (yn < 0) begin
          m_y = 0; m_v = 0; m_st = 3;
        end else begin
          m_y = yn; m_v = m_v + 1;
          if (m_v >= 0) m_st = 3;
        end
      end
      default: begin
        yn = m_y + m_v;
        if (yn >= 416) begin
          m_y = 416; m_v = 0; m_st = mv ? 1 : 0;
        end else begin
          m_y = yn; m_v = (m_v + 1 > 12) ? 12 : m_v + 1;
        end
      end
    endcase
  endtask

  // One game tick: raise the level, predict, then give the DUT a bounded window
  task automatic do_tick();
    exp_t t;
    @(posedge clock50mHz); #2;
    game_tick = 1'b1;
    if (enable) begin
      model_step();
      t.x = m_x; t.y = m_y; t.f = m_f; t.st = m_st;
      q.push_back(t);
    end
    repeat (3) @(posedge clock50mHz);
    #2 game_tick = 1'b0;
    repeat (2) @(posedge clock50mHz);
    #2;
    chk("strobe_seen", q.size(), 0);
    if (q.size() != 0) q.delete();
  endtask

  // Monitor: every update strobe consumes one predicted result
  always @(negedge clock50mHz) begin
    if (update_strobe === 1'b1) begin
      n_strobe++;
      chk("strobe_width", int'(prev_strobe), 0);
      if (q.size() == 0) begin
        chk("unexpected_strobe", 1, 0);
      end else begin
        e = q.pop_front();
        chk("sb_pos_x", int'(pos_x), e.x);
        chk("sb_pos_y", int'(pos_y), e.y);
        chk("sb_facing", int'(facing_left), e.f);
        chk("sb_state", int'(motion_state), e.st);
      end
    end
    prev_strobe <= update_strobe;
  end

  int s0;
  int max_y;

  initial begin
    reset = 1'b1; game_tick = 1'b1; enable = 1'b1;
    btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;
    model_reset();

    // Reset with tick held high, then keep it high after release
    repeat (10) @(posedge clock50mHz);
    #2 reset = 1'b0;
    repeat (1000) @(posedge clock50mHz);
    #2;
    chk("rst_pos_x", int'(pos_x), 32);
    chk("rst_pos_y", int'(pos_y), 416);
    chk("rst_state", int'(motion_state), 0);
    chk("rst_facing", int'(facing_left), 0);
    chk("rst_no_strobe", n_strobe, 0);
    game_tick = 1'b0;
    repeat (3) @(posedge clock50mHz);
    #2;

    // Walk right five ticks, then release
    btn_right = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      do_tick();
      chk("walk_r_x", int'(pos_x), 32 + 2 * i);
      chk("walk_r_state", int'(motion_state), 1);
    end
    chk("walk_r_facing", int'(facing_left), 0);
    chk("walk_r_strobes", n_strobe, 5);
    btn_right = 1'b0;
    do_tick();
    chk("release_x", int'(pos_x), 42);
    chk("release_state", int'(motion_state), 0);

    // Back to start position, walk left into the screen edge
    @(posedge clock50mHz); #2 reset = 1'b1;
    @(posedge clock50mHz); #2 reset = 1'b0;
    model_reset();
    chk("rst2_pos_x", int'(pos_x), 32);
    btn_left = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      do_tick();
      chk("walk_l_x", int'(pos_x), (32 - 2 * i > 0) ? 32 - 2 * i : 0);
      chk("walk_l_state", int'(motion_state), 1);
      chk("walk_l_facing", int'(facing_left), 1);
    end
    btn_left = 1'b0;

    // Single-tick jump pulse, full trajectory
    btn_jump = 1'b1;
    do_tick();
    btn_jump = 1'b0;
    chk("jump_t1_y", int'(pos_y), 404);
    chk("jump_t1_state", int'(motion_state), 2);
    max_y = int'(pos_y);
    for (int t = 2; t <= 25; t++) begin
      do_tick();
      if (int'(pos_y) > max_y) max_y = int'(pos_y);
      if (t == 11) chk("jump_t11_state", int'(motion_state), 2);
      if (t == 12) begin
        chk("jump_apex_y", int'(pos_y), 338);
        chk("jump_apex_state", int'(motion_state), 3);
      end
      if (t == 24) chk("jump_t24_y", int'(pos_y), 404);
    end
    chk("land_y", int'(pos_y), 416);
    chk("land_state", int'(motion_state), 0);
    chk("max_y_le_floor", int'(max_y > 416), 0);

    // Freeze ticks 3-5 of a jump with enable low
    btn_jump = 1'b1;
    do_tick();
    btn_jump = 1'b0;
    do_tick();
    chk("frz_t2_y", int'(pos_y), 393);
    enable = 1'b0;
    s0 = n_strobe;
    for (int i = 0; i < 3; i++) do_tick();
    chk("frz_y", int'(pos_y), 393);
    chk("frz_state", int'(motion_state), 2);
    chk("frz_no_strobe", n_strobe, s0);
    enable = 1'b1;
    do_tick();
    chk("resume_t3_y", int'(pos_y), 383);
    for (int t = 4; t <= 25; t++) do_tick();
    chk("resume_land_y", int'(pos_y), 416);
    chk("resume_land_state", int'(motion_state), 0);

    // Reset pulse in the middle of the fall
    btn_jump = 1'b1;
    do_tick();
    btn_jump = 1'b0;
    for (int t = 2; t <= 14; t++) do_tick();
    chk("midfall_state", int'(motion_state), 3);
    chk("midfall_y", int'(pos_y), 339);
    @(posedge clock50mHz); #2 reset = 1'b1;
    @(posedge clock50mHz); #2 reset = 1'b0;
    model_reset();
    @(negedge clock50mHz);
    chk("abort_pos_x", int'(pos_x), 32);
    chk("abort_pos_y", int'(pos_y), 416);
    chk("abort_state", int'(motion_state), 0);
    do_tick();
    chk("abort_next_state", int'(motion_state), 0);
    chk("abort_next_y", int'(pos_y), 416);
    chk("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
